// File: rtl/expu_res_collector.sv
// ---------------------------------------------------------------------------
// expu_res_collector
//
// Collects results from a fixed-latency expu_top pipeline (enable tied high)
// into a first-word-fall-through FIFO. A tag shift register follows each
// issued operand through the pipeline, so the matching result is captured on
// the exact edge it appears. Operands are admitted only when the FIFO has
// room for every result already in flight. This means a capture can never
// overflow the FIFO, and results leave in the same order they were issued.
//
// Optional feature:
//   EXPU_COLLECTOR_SPECIAL_FLAG_EN - when defined, special_o is a sticky flag.
//   It is set by any captured result whose exponent field is all ones.
//   When undefined, special_o is constant 0 and no flag register is built.
//
// Parameters:
//   WIDTH   - result width (sign + 8-bit exponent + mantissa)
//   LATENCY - expu_top cycles from operand to result, 1..8
//   DEPTH   - FIFO entries, power of two, >= 2
//
// Ports:
//   clk_i       in   clock, all state updates on the rising edge
//   rst_ni      in   asynchronous active-low reset
//   clear_i     in   synchronous flush of buffered and in-flight results
//   in_valid_i  in   upstream offers an operand to expu_top this cycle
//   in_ready_o  out  an operand may be issued this cycle
//   expu_res_i  in   expu_top res_o
//   out_valid_o out  out_data_o holds a result
//   out_ready_i in   downstream accepts the result
//   out_data_o  out  oldest buffered result
//   count_o     out  results popped since reset/clear, wraps at 2^32
//   special_o   out  sticky all-ones-exponent flag (optional)
// ---------------------------------------------------------------------------
module expu_res_collector #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] expu_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [31:0]      count_o,
  output logic             special_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // This width is enough to hold fifo_count plus one tag for every pipeline stage.
  localparam int SW = $clog2(DEPTH + LATENCY) + 1;

  logic [LATENCY-1:0] tag_q;
  logic [LATENCY-1:0] tag_d;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_count;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [SW-1:0]      occupancy;
  logic               issue;
  logic               capture;
  logic               pop;

  // Slots already committed: buffered entries plus results still in the
  // pipeline. Admitting only below DEPTH is what keeps captures from
  // overflowing. Gating with rst_ni keeps ready low during reset.
  always_comb begin
    occupancy = SW'(fifo_count);
    for (int i = 0; i < LATENCY; i++) begin
      occupancy = occupancy + SW'(tag_q[i]);
    end
  end

  assign in_ready_o  = rst_ni && !clear_i && (occupancy < SW'(DEPTH));
  assign issue       = in_valid_i && in_ready_o;
  assign capture     = tag_q[LATENCY-1];
  assign out_valid_o = (fifo_count != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = mem[rd_ptr];

  // Next tag vector. The issue bit enters at stage 0, and the last stage
  // marks the edge where expu_res_i holds the matching result.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = issue;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Control state. A clear wins over issue, capture and pop, so in-flight
  // tags are dropped and their results are never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      count_o    <= '0;
    end else if (clear_i) begin
      tag_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      count_o    <= '0;
    end else begin
      tag_q <= tag_d;
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count_o <= count_o + 32'd1;
      end
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage is not reset. A capture into an empty FIFO is seen only through
  // mem on the following cycle; there is no same-cycle bypass.
  always_ff @(posedge clk_i) begin
    if (capture && !clear_i) begin
      mem[wr_ptr] <= expu_res_i;
    end
  end

`ifdef EXPU_COLLECTOR_SPECIAL_FLAG_EN
  logic special_q;

  // Sticky flag. Once any captured result has exponent 0xFF, the flag holds
  // until reset or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      special_q <= 1'b0;
    end else if (clear_i) begin
      special_q <= 1'b0;
    end else if (capture && (expu_res_i[WIDTH-2 -: 8] == 8'hFF)) begin
      special_q <= 1'b1;
    end
  end

  assign special_o = special_q;
`else
  assign special_o = 1'b0;
`endif

endmodule

// File: tb/tb_expu_res_collector.sv
// ---------------------------------------------------------------------------
// tb_expu_res_collector
//
// Bench for expu_res_collector with WIDTH=16, LATENCY=2, DEPTH=8.
//
// The stimulus process includes a small model of expu_top: a LATENCY-deep
// pipeline that carries each issued operand through unchanged. Every accepted
// issue pushes its operand into a scoreboard queue. A separate monitor runs
// on the falling edge: it compares the FIFO head with the queue front, pops
// the queue on handshakes, and tracks the expected pop count. When a pipeline
// stage holds no issued operand, the model drives 16'hDEAD, so a wrong
// capture edge shows up as bad data.
// ---------------------------------------------------------------------------
module tb_expu_res_collector;

  localparam int LAT = 2;
  localparam int DEP = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] expu_res_i = 16'h0000;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;
  logic [31:0] count_o;
  logic        special_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] sb_q [$];
  logic [15:0] pipe_val [LAT];
  logic        pipe_ok  [LAT];
  logic [15:0] pend_op = 16'h0000;
  logic        pend_issue = 1'b0;
  logic [31:0] model_count = 32'd0;

  expu_res_collector #(
    .WIDTH  (16),
    .LATENCY(LAT),
    .DEPTH  (DEP)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .expu_res_i (expu_res_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .count_o    (count_o),
    .special_o  (special_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock cycle of stimulus. After the rising edge, the expu model
  // pipeline advances and the new inputs are driven. At the falling edge,
  // the task decides whether this cycle issues and updates the scoreboard.
  task automatic applyStimulus(input logic v, input logic [15:0] op,
                               input logic rdy, input logic clr,
                               output logic rdy_seen);
    @(posedge clk_i);
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_val[i] = pipe_val[i-1];
      pipe_ok[i]  = pipe_ok[i-1];
    end
    pipe_val[0] = pend_op;
    pipe_ok[0]  = pend_issue;
    #1;
    in_valid_i  = v;
    out_ready_i = rdy;
    clear_i     = clr;
    expu_res_i  = pipe_ok[LAT-1] ? pipe_val[LAT-1] : 16'hDEAD;
    @(negedge clk_i);
    rdy_seen   = in_ready_o;
    pend_issue = v && in_ready_o;
    pend_op    = op;
    if (clr) begin
      sb_q.delete();
    end else if (pend_issue) begin
      sb_q.push_back(op);
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    logic r;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 16'h0000, rdy, 1'b0, r);
    end
  endtask

  task automatic drainAll(input int budget);
    logic r;
    int   n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid_o) && n < budget) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, r);
      n++;
    end
    checkOutput("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: compares data and count, and flags any output that appears
  // while nothing is expected.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        checkOutput("count_track", count_o, model_count);
        if (clear_i) begin
          model_count = 32'd0;
        end else if (sb_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'(out_valid_o), 32'd0);
        end else if (out_valid_o) begin
          checkOutput("data_order", 32'(out_data_o), 32'(sb_q[0]));
          if (out_ready_i) begin
            void'(sb_q.pop_front());
            model_count = model_count + 32'd1;
          end
        end
      end
    end
  end

  initial begin
    logic r;
    int   stalls;
    int   issues;
    logic exp_special;

`ifdef EXPU_COLLECTOR_SPECIAL_FLAG_EN
    exp_special = 1'b1;
`else
    exp_special = 1'b0;
`endif
    for (int i = 0; i < LAT; i++) begin
      pipe_val[i] = 16'h0000;
      pipe_ok[i]  = 1'b0;
    end

    // Reset: in_valid is high, but nothing may be accepted.
    in_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_count", count_o, 32'd0);
    checkOutput("rst_special", 32'(special_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni     = 1'b1;
    in_valid_i = 1'b0;

    // Single operand: visible two edges after the issue edge.
    idle(1'b0, 2);
    applyStimulus(1'b1, 16'h402D, 1'b0, 1'b0, r);
    checkOutput("single_ready", 32'(r), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, r);
    checkOutput("lat_valid_e1", 32'(out_valid_o), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, r);
    checkOutput("lat_valid_e2", 32'(out_valid_o), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, r);
    checkOutput("lat_valid_e3", 32'(out_valid_o), 32'd1);
    checkOutput("lat_data", 32'(out_data_o), 32'h0000402D);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, r);
    checkOutput("hold_data", 32'(out_data_o), 32'h0000402D);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, r);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, r);
    checkOutput("single_count", count_o, 32'd1);
    checkOutput("single_empty", 32'(out_valid_o), 32'd0);

    // Clear, then sweep 768 back-to-back operands.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, r);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, r);
    checkOutput("clear_count", count_o, 32'd0);
    stalls = 0;
    for (int e = 127; e <= 132; e++) begin
      for (int m = 0; m < 128; m++) begin
        applyStimulus(1'b1, {1'b0, 8'(e), 7'(m)}, 1'b1, 1'b0, r);
        if (!r) stalls++;
      end
    end
    checkOutput("sweep_stalls", 32'(stalls), 32'd0);
    drainAll(50);
    idle(1'b1, 1);
    checkOutput("sweep_count", count_o, 32'd768);
    checkOutput("sweep_special", 32'(special_o), 32'd0);

    // Backpressure: exactly DEPTH issues are accepted.
    issues = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 16'h4100 + 16'(i), 1'b0, 1'b0, r);
      if (r) issues++;
    end
    checkOutput("bp_issues", 32'(issues), 32'd8);
    checkOutput("bp_ready_low", 32'(in_ready_o), 32'd0);
    checkOutput("bp_full_valid", 32'(out_valid_o), 32'd1);

    // Release: ready returns only after the first pop.
    applyStimulus(1'b1, 16'h4200, 1'b1, 1'b0, r);
    checkOutput("ready_before_pop", 32'(r), 32'd0);
    applyStimulus(1'b1, 16'h4201, 1'b1, 1'b0, r);
    checkOutput("ready_after_pop", 32'(r), 32'd1);
    drainAll(50);

    // Clear with 3 results buffered and 2 in flight.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h4300 + 16'(i), 1'b0, 1'b0, r);
    end
    checkOutput("pre_clear_valid", 32'(out_valid_o), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, r);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, r);
    checkOutput("post_clear_valid", 32'(out_valid_o), 32'd0);
    checkOutput("post_clear_count", count_o, 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, r);
      checkOutput("no_stale", 32'(out_valid_o), 32'd0);
    end

    // Special flag: an all-ones exponent sets it, and clear drops it.
    applyStimulus(1'b1, 16'h7F80, 1'b1, 1'b0, r);
    drainAll(20);
    idle(1'b1, 2);
    checkOutput("special_set", 32'(special_o), 32'(exp_special));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, r);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, r);
    checkOutput("special_cleared", 32'(special_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/expu_res_collector.md
EXPU_RES_COLLECTOR -- requirements
Module: expu_res_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning result width (sign + 8-bit exponent + 7-bit mantissa).
REQ-002 SHALL have parameter LATENCY, default 2, meaning expu_top clock cycles from operand to result (2 with mantissa correction enabled); legal range 1..8.
REQ-003 SHALL have parameter DEPTH, default 8, meaning result FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port clear_i, input, 1 bit, synchronous flush.
REQ-007 SHALL have port in_valid_i, input, 1 bit; the upstream offers an operand to expu_top this cycle.
REQ-008 SHALL have port in_ready_o, output, 1 bit; an operand may be issued this cycle.
REQ-009 SHALL have port expu_res_i, input, WIDTH bits, driven by expu_top res_o, whose enable_i is tied high.
REQ-010 SHALL have port out_valid_o, output, 1 bit; out_data_o holds a result.
REQ-011 SHALL have port out_ready_i, input, 1 bit; the downstream accepts a result.
REQ-012 SHALL have port out_data_o, output, WIDTH bits; the oldest buffered result.
REQ-013 SHALL have port count_o, output, 32 bits; the number of results popped since reset or clear.
REQ-014 SHALL have port special_o, output, 1 bit; sticky flag set when a captured result has an all-ones exponent.

Function
REQ-015 An issue SHALL occur when in_valid_i and in_ready_o are both high at a rising edge.
REQ-016 A LATENCY-bit tag shift register SHALL advance every cycle, with tag[0] taking the issue bit.
REQ-017 On the edge where tag[LATENCY-1] is high, expu_res_i SHALL be written into the FIFO; an issue at edge k is therefore captured at edge k+LATENCY.
REQ-018 in_ready_o SHALL be combinational and equal to ((fifo_count + popcount(tags)) < DEPTH) && !clear_i.
REQ-019 in_ready_o SHALL NOT depend on in_valid_i.
REQ-020 As a consequence of REQ-018, a capture SHALL never find the FIFO full.
REQ-021 The FIFO SHALL be first-word-fall-through: out_valid_o = (fifo_count != 0), and out_data_o is the head entry.
REQ-022 A pop SHALL occur when out_valid_o and out_ready_i are both high.
REQ-023 out_data_o SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-024 A simultaneous capture and pop SHALL leave fifo_count unchanged, including at count 1 and at count DEPTH.
REQ-025 When a capture and a pop occur with the FIFO empty, the captured entry SHALL become visible in the next cycle and SHALL NOT be bypassed in the same cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 fifo_count SHALL be log2(DEPTH)+1 bits wide.
REQ-028 count_o SHALL increment by 1 per pop and wrap from 0xFFFFFFFF to 0.
REQ-029 The response order SHALL equal the issue order.

Reset
REQ-030 While rst_ni is low, in the same cycle and asynchronously: tags = 0, pointers = 0, fifo_count = 0, count_o = 0, special_o = 0, out_valid_o = 0.
REQ-031 While rst_ni is low, in_ready_o SHALL be low.
REQ-032 FIFO storage SHALL NOT be reset; out_data_o is don't-care while out_valid_o is 0.
REQ-033 A clear_i high at an edge SHALL restore every reset value at that edge.
REQ-034 clear_i SHALL take priority over issue, capture and pop in the same cycle; in-flight tags are discarded.
REQ-035 A reset or clear applied mid-operation SHALL discard all buffered and in-flight results without emitting them.

Configuration
REQ-036 With macro EXPU_COLLECTOR_SPECIAL_FLAG_EN defined, special_o SHALL be set on any capture where expu_res_i[WIDTH-2 -: 8] == 8'hFF.
REQ-037 With EXPU_COLLECTOR_SPECIAL_FLAG_EN defined, special_o SHALL remain set until reset or clear.
REQ-038 With EXPU_COLLECTOR_SPECIAL_FLAG_EN undefined, special_o SHALL be tied to 0 and no flag register SHALL exist.

Verification
REQ-039 Reset, then issue one operand at edge 5 with LATENCY=2 and the bench driving expu_res_i = 16'h402D at edge 7 -> out_valid_o rises after edge 7, out_data_o = 16'h402D, count_o = 1 after the pop.
REQ-040 Issue 768 back-to-back operands (exponent sweep 127..132, mantissa 0..127) with out_ready_i held high -> in_ready_o stays high, results arrive in order, count_o = 768.
REQ-041 Hold out_ready_i low and keep in_valid_i high -> exactly 8 issues are accepted, in_ready_o falls after the 8th issue, no capture is lost.
REQ-042 Release out_ready_i -> in_ready_o reasserts after the first pop.
REQ-043 Pulse clear_i with 3 results buffered and 2 in flight -> out_valid_o = 0 on the next cycle, count_o = 0, and no stale result ever appears.
REQ-044 With EXPU_COLLECTOR_SPECIAL_FLAG_EN defined, capture 16'h7F80 -> special_o = 1 until clear; without the macro, special_o = 0.
